// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, line levels and default sizing
package uart_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

    localparam int UART_DEF_CLKS_PER_BIT = 16;
    localparam int UART_DEF_DATA_WIDTH   = 8;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: clocks-per-bit counter, one-cycle tick at count CLKS_PER_BIT-1
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);
    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick_o = cnt_q == LAST;
    assign cnt_d  = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;

    // Count within the current bit window, wrapping at the bit boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter (start, data LSB first, optional parity via UART_TX_PARITY_EN, stop)
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = UART_DEF_DATA_WIDTH,
    parameter int CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_serial,
    output logic                  tx_busy,
    output logic                  tx_done
);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    uart_state_e           state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [BW-1:0]         bit_q;
    logic                  serial_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  baud_tick;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q;
`endif

    // The counter sits at zero in IDLE so the start bit gets a full window
    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == ST_IDLE),
        .tick_o (baud_tick)
    );

    assign tx_serial = serial_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;

    // Frame sequencer; line level is registered one bit ahead of each state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            serial_q <= UART_IDLE_LVL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (tx_start) begin
                    state_q  <= ST_START;
                    shift_q  <= tx_data;
                    serial_q <= UART_START_LVL;
                    busy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_q <= ^tx_data ^ (PARITY_ODD != 0);
`endif
                end
                ST_START: if (baud_tick) begin
                    state_q  <= ST_DATA;
                    serial_q <= shift_q[0];
                    bit_q    <= '0;
                end
                ST_DATA: if (baud_tick) begin
                    if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_q  <= ST_PARITY;
                        serial_q <= parity_q;
`else
                        state_q  <= ST_STOP;
                        serial_q <= UART_IDLE_LVL;
`endif
                    end else begin
                        shift_q  <= shift_q >> 1;
                        serial_q <= shift_q[1];
                        bit_q    <= bit_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: if (baud_tick) begin
                    state_q  <= ST_STOP;
                    serial_q <= UART_IDLE_LVL;
                end
`endif
                ST_STOP: if (baud_tick) begin
                    state_q  <= ST_IDLE;
                    serial_q <= UART_IDLE_LVL;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    serial_q <= UART_IDLE_LVL;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench decoding the serial line against queued words
module tb_uart_tx;
    localparam int DW  = 8;
    localparam int CPB = 16;
    localparam bit PODD = 1'b0;
`ifdef UART_TX_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_start = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_serial;
    logic          tx_busy;
    logic          tx_done;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int frames = 0;
    int last_start = 0;
    int prev_start = 0;
    logic [DW-1:0] sb[$];

    uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_ODD(int'(PODD))) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (tx_done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; tx_start is seen by the next posedge
    task automatic drive_start(input logic [DW-1:0] w);
        tx_data  = w;
        tx_start = 1'b1;
        sb.push_back(w);
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = ~w;
    endtask

    task automatic wait_frames(input int n);
        int t = 0;
        while (frames < n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("frame_timeout", 32'(frames >= n), 1);
    endtask

    // Serial decoder: a low line in idle marks frame cycle 0
    always begin
        @(negedge clk);
        if (!rst && tx_serial == 1'b0) begin
            logic [NB-1:0] bits;
            logic [DW-1:0] exp;
            int glitch;
            int busy_n;
            bit abort;
            bits = '0;
            glitch = 0;
            busy_n = 0;
            abort = 0;
            prev_start = last_start;
            last_start = cyc;
            chk("sb_nonempty", 32'(sb.size() > 0), 1);
            exp = (sb.size() > 0) ? sb.pop_front() : '1;
            for (int k = 0; k < NB * CPB && !abort; k++) begin
                if (k > 0) @(negedge clk);
                if (rst) abort = 1;
                else begin
                    if (k % CPB == 0) bits[k / CPB] = tx_serial;
                    else if (tx_serial !== bits[k / CPB]) glitch++;
                    if (tx_busy) busy_n++;
                end
            end
            if (!abort) begin
                @(negedge clk);
                if (!rst) begin
                    chk("start_bit", 32'(bits[0]), 0);
                    chk("word", 32'(bits[DW:1]), 32'(exp));
`ifdef UART_TX_PARITY_EN
                    chk("parity", 32'(bits[DW+1]), 32'(^exp ^ PODD));
`endif
                    chk("stop_bit", 32'(bits[NB-1]), 1);
                    chk("bit_width", glitch, 0);
                    chk("busy_cycles", busy_n, NB * CPB);
                    chk("done_pulse", {tx_done, tx_busy, tx_serial}, 3'b101);
                    frames++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int d0;
        repeat (5) @(negedge clk);
        chk("rst_serial", 32'(tx_serial), 1);
        chk("rst_busy", 32'(tx_busy), 0);
        chk("rst_done", 32'(tx_done), 0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("idle_serial", 32'(tx_serial), 1);
        chk("idle_busy", 32'(tx_busy), 0);
        chk("idle_done_cnt", done_cnt, 0);

        // Single frame
        d0 = done_cnt;
        @(negedge clk);
        drive_start(8'hA5);
        wait_frames(1);
        repeat (3) @(negedge clk);
        chk("a5_done_cnt", done_cnt - d0, 1);

        // Start while busy is ignored
        d0 = done_cnt;
        @(negedge clk);
        drive_start(8'h3C);
        repeat (39) @(negedge clk);
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_frames(2);
        repeat (200) @(negedge clk);
        chk("busy_rej_done_cnt", done_cnt - d0, 1);
        chk("busy_rej_frames", frames, 2);

        // Back-to-back on the done cycle
        @(negedge clk);
        drive_start(8'h80);
        repeat (NB * CPB) @(negedge clk);
        drive_start(8'h01);
        wait_frames(4);
        chk("b2b_gap", last_start - prev_start, NB * CPB + 1);

        // Asynchronous reset during data bit 3
        d0 = done_cnt;
        f0 = frames;
        @(negedge clk);
        drive_start(8'h55);
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        chk("bit3_level", 32'(tx_serial), 0);
        rst = 1'b1;
        #1;
        chk("arst_serial", 32'(tx_serial), 1);
        chk("arst_busy", 32'(tx_busy), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("arst_no_done", done_cnt - d0, 0);
        chk("arst_no_frame", frames - f0, 0);
        drive_start(8'h0F);
        wait_frames(f0 + 1);

`ifdef UART_TX_PARITY_EN
        @(negedge clk);
        drive_start(8'h07);
        wait_frames(f0 + 2);
`endif

        repeat (50) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("idle_end_serial", 32'(tx_serial), 1);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
